// File: rtl/clk_meas_checker_if.sv
// Clock VIP measurement bus between the environment (master) and the receive-side checker (slave).
// The environment drives the measured clock and expectations; the checker returns results.
interface clk_meas_checker_if #(
    parameter int CNT_W = 16
);
    logic             enable;
    logic             clock_in;
    logic [CNT_W-1:0] exp_period;
    logic [CNT_W-1:0] exp_high;
    logic [CNT_W-1:0] tol;
    logic             clear_err;
    logic [CNT_W-1:0] meas_period;
    logic [CNT_W-1:0] meas_high;
    logic             meas_valid;
    logic             clock_active;
    logic             config_error;
    logic             period_error;
    logic             duty_error;
    logic [15:0]      err_count;

    modport master (
        output enable, clock_in, exp_period, exp_high, tol, clear_err,
        input  meas_period, meas_high, meas_valid, clock_active,
               config_error, period_error, duty_error, err_count
    );

    modport slave (
        input  enable, clock_in, exp_period, exp_high, tol, clear_err,
        output meas_period, meas_high, meas_valid, clock_active,
               config_error, period_error, duty_error, err_count
    );
endinterface

// File: rtl/clk_meas_checker.sv
// Oversamples an asynchronous clock, measures its period and high time in clk cycles,
// and flags deviations from the expected values beyond a jitter tolerance.
module clk_meas_checker #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    clk_meas_checker_if.slave bus
);

    typedef enum logic [1:0] {IDLE, WAIT_RISE, MEASURE} state_e;

    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_d_q;
    logic                   s, rise, fall;
    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       pcnt_q, pcnt_d, hcnt_q, hcnt_d, high_hold_q, high_hold_d;
    logic [CNT_W-1:0]       meas_period_q, meas_period_d, meas_high_q, meas_high_d;
    logic                   meas_valid_q, meas_valid_d, clock_active_q, clock_active_d;
    logic                   period_err_q, period_err_d, duty_err_q, duty_err_d;
    logic [15:0]            err_count_q, err_count_d;
    logic                   cfg_err, timeout, check_en, per_bad, duty_bad, fail;

    function automatic logic [CNT_W-1:0] abs_diff(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d_q;
    assign fall = ~s & s_d_q;

    // Gated by rst_n so that every output reads 0 while reset is held
    assign cfg_err = rst_n & ((bus.exp_period == '0) | (bus.exp_high == '0) |
                              (bus.exp_high >= bus.exp_period));

    assign timeout  = bus.enable & (state_q == MEASURE) & ~rise & (pcnt_q >= TIMEOUT_V);
    assign check_en = meas_valid_q & ~cfg_err;
    assign per_bad  = abs_diff(meas_period_q, bus.exp_period) > bus.tol;
    assign duty_bad = abs_diff(meas_high_q, bus.exp_high) > bus.tol;
    assign fail     = (check_en & (per_bad | duty_bad)) | timeout;

    always_comb begin
        state_d        = state_q;
        pcnt_d         = pcnt_q;
        hcnt_d         = hcnt_q;
        high_hold_d    = high_hold_q;
        meas_period_d  = meas_period_q;
        meas_high_d    = meas_high_q;
        meas_valid_d   = 1'b0;
        clock_active_d = clock_active_q;
        if (!bus.enable) begin
            state_d        = IDLE;
            clock_active_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: state_d = WAIT_RISE;
                WAIT_RISE: begin
                    if (rise) begin
                        pcnt_d  = CNT_W'(1);
                        hcnt_d  = CNT_W'(1);
                        state_d = MEASURE;
                    end
                end
                MEASURE: begin
                    if (pcnt_q != CNT_MAX) pcnt_d = pcnt_q + CNT_W'(1);
                    if (s_d_q && (hcnt_q != CNT_MAX)) hcnt_d = hcnt_q + CNT_W'(1);
                    if (fall) high_hold_d = hcnt_q;
                    // Reload on the same rise that closes the period so periods chain without gaps
                    if (rise) begin
                        meas_period_d  = pcnt_q;
                        meas_high_d    = high_hold_q;
                        meas_valid_d   = 1'b1;
                        clock_active_d = 1'b1;
                        pcnt_d         = CNT_W'(1);
                        hcnt_d         = CNT_W'(1);
                    end else if (timeout) begin
                        clock_active_d = 1'b0;
                        state_d        = WAIT_RISE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // A clear and a new failure in the same cycle leave the failure recorded
    always_comb begin
        period_err_d = bus.clear_err ? 1'b0 : period_err_q;
        duty_err_d   = bus.clear_err ? 1'b0 : duty_err_q;
        err_count_d  = bus.clear_err ? 16'd0 : err_count_q;
        if (check_en && per_bad) period_err_d = 1'b1;
        if (check_en && duty_bad) duty_err_d = 1'b1;
        if (timeout && !cfg_err) period_err_d = 1'b1;
        if (fail && (err_count_d != 16'hFFFF)) err_count_d = err_count_d + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q         <= '0;
            s_d_q          <= 1'b0;
            state_q        <= IDLE;
            pcnt_q         <= '0;
            hcnt_q         <= '0;
            high_hold_q    <= '0;
            meas_period_q  <= '0;
            meas_high_q    <= '0;
            meas_valid_q   <= 1'b0;
            clock_active_q <= 1'b0;
            period_err_q   <= 1'b0;
            duty_err_q     <= 1'b0;
            err_count_q    <= 16'd0;
        end else begin
            sync_q         <= {sync_q[SYNC_STAGES-2:0], bus.clock_in};
            s_d_q          <= s;
            state_q        <= state_d;
            pcnt_q         <= pcnt_d;
            hcnt_q         <= hcnt_d;
            high_hold_q    <= high_hold_d;
            meas_period_q  <= meas_period_d;
            meas_high_q    <= meas_high_d;
            meas_valid_q   <= meas_valid_d;
            clock_active_q <= clock_active_d;
            period_err_q   <= period_err_d;
            duty_err_q     <= duty_err_d;
            err_count_q    <= err_count_d;
        end
    end

    assign bus.meas_period  = meas_period_q;
    assign bus.meas_high    = meas_high_q;
    assign bus.meas_valid   = meas_valid_q;
    assign bus.clock_active = clock_active_q;
    assign bus.config_error = cfg_err;
    assign bus.period_error = period_err_q;
    assign bus.duty_error   = duty_err_q;
    assign bus.err_count    = err_count_q;

endmodule

// File: tb/tb_clk_meas_checker.sv
// Directed bench for clk_meas_checker: table of steady-clock vectors plus cycle-exact
// sequences for latency, timeout, same-cycle clear, enable drop and mid-period reset.
module tb_clk_meas_checker;

    localparam int TMO = 64;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    clk_meas_checker_if #(.CNT_W(16)) bus ();

    clk_meas_checker #(.CNT_W(16), .SYNC_STAGES(2), .TIMEOUT_CYC(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          period;
        int          high;
        logic [15:0] expP;
        logic [15:0] expH;
        logic [15:0] tol;
        logic [15:0] measP;
        logic [15:0] measH;
        logic        perErr;
        logic        dutyErr;
        logic        cfgErr;
        logic [15:0] errCnt;
    } vec_t;

    vec_t vecs[9];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " meas_period"}, 32'(bus.meas_period), 0);
        checkOutput({tag, " meas_high"}, 32'(bus.meas_high), 0);
        checkOutput({tag, " meas_valid"}, 32'(bus.meas_valid), 0);
        checkOutput({tag, " clock_active"}, 32'(bus.clock_active), 0);
        checkOutput({tag, " config_error"}, 32'(bus.config_error), 0);
        checkOutput({tag, " period_error"}, 32'(bus.period_error), 0);
        checkOutput({tag, " duty_error"}, 32'(bus.duty_error), 0);
        checkOutput({tag, " err_count"}, 32'(bus.err_count), 0);
    endtask

    // Park in IDLE with errors cleared, load expectations, then re-enable with clock_in low
    task automatic prepare(input logic [15:0] expP, input logic [15:0] expH, input logic [15:0] tol);
        bus.enable     = 1'b0;
        bus.clock_in   = 1'b0;
        bus.clear_err  = 1'b1;
        bus.exp_period = expP;
        bus.exp_high   = expH;
        bus.tol        = tol;
        repeat (4) @(negedge clk);
        bus.clear_err = 1'b0;
        bus.enable    = 1'b1;
        @(negedge clk);
    endtask

    task automatic applyStimulus(input vec_t v);
        prepare(v.expP, v.expH, v.tol);
        for (int i = 0; i <= 3 * v.period; i++) begin
            @(negedge clk);
            bus.clock_in = ((i % v.period) < v.high);
        end
        repeat (6) @(negedge clk);
    endtask

    initial begin
        int firstMv;
        int secondMv;
        int mvCount;

        vecs[0] = '{10, 4, 16'd10, 16'd4,  16'd0, 16'd10, 16'd4, 1'b0, 1'b0, 1'b0, 16'd0};
        vecs[1] = '{12, 4, 16'd10, 16'd4,  16'd1, 16'd12, 16'd4, 1'b1, 1'b0, 1'b0, 16'd3};
        vecs[2] = '{12, 4, 16'd10, 16'd4,  16'd2, 16'd12, 16'd4, 1'b0, 1'b0, 1'b0, 16'd0};
        vecs[3] = '{10, 6, 16'd10, 16'd4,  16'd2, 16'd10, 16'd6, 1'b0, 1'b0, 1'b0, 16'd0};
        vecs[4] = '{10, 6, 16'd10, 16'd4,  16'd1, 16'd10, 16'd6, 1'b0, 1'b1, 1'b0, 16'd3};
        vecs[5] = '{12, 6, 16'd10, 16'd4,  16'd1, 16'd12, 16'd6, 1'b1, 1'b1, 1'b0, 16'd3};
        vecs[6] = '{12, 6, 16'd10, 16'd10, 16'd0, 16'd12, 16'd6, 1'b0, 1'b0, 1'b1, 16'd0};
        vecs[7] = '{8,  3, 16'd9,  16'd3,  16'd1, 16'd8,  16'd3, 1'b0, 1'b0, 1'b0, 16'd0};
        vecs[8] = '{5,  2, 16'd10, 16'd4,  16'd3, 16'd5,  16'd2, 1'b1, 1'b0, 1'b0, 16'd3};

        rst_n          = 1'b0;
        bus.enable     = 1'b0;
        bus.clock_in   = 1'b0;
        bus.clear_err  = 1'b0;
        bus.exp_period = 16'd10;
        bus.exp_high   = 16'd4;
        bus.tol        = 16'd0;
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 9; k++) begin
            applyStimulus(vecs[k]);
            checkOutput($sformatf("v%0d meas_period", k), 32'(bus.meas_period), 32'(vecs[k].measP));
            checkOutput($sformatf("v%0d meas_high", k), 32'(bus.meas_high), 32'(vecs[k].measH));
            checkOutput($sformatf("v%0d period_error", k), 32'(bus.period_error), 32'(vecs[k].perErr));
            checkOutput($sformatf("v%0d duty_error", k), 32'(bus.duty_error), 32'(vecs[k].dutyErr));
            checkOutput($sformatf("v%0d config_error", k), 32'(bus.config_error), 32'(vecs[k].cfgErr));
            checkOutput($sformatf("v%0d err_count", k), 32'(bus.err_count), 32'(vecs[k].errCnt));
            checkOutput($sformatf("v%0d clock_active", k), 32'(bus.clock_active), 1);
        end

        // First measurement appears 3 samples after the second driven rise, then every period
        prepare(16'd10, 16'd4, 16'd0);
        firstMv = -1; secondMv = -1; mvCount = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.meas_valid) begin
                mvCount++;
                if (firstMv < 0) begin
                    firstMv = i;
                    checkOutput("latency meas_period", 32'(bus.meas_period), 10);
                    checkOutput("latency meas_high", 32'(bus.meas_high), 4);
                end else if (secondMv < 0) secondMv = i;
            end
            bus.clock_in = ((i % 10) < 4);
        end
        checkOutput("latency first meas_valid", 32'(firstMv), 13);
        checkOutput("latency second meas_valid", 32'(secondMv), 23);
        checkOutput("latency meas_valid count", 32'(mvCount), 2);
        checkOutput("latency err_count", 32'(bus.err_count), 0);

        // Clock stops low after the rise driven at 20; restarts with rises at 100 and 110
        prepare(16'd10, 16'd4, 16'd0);
        for (int i = 0; i <= 115; i++) begin
            @(negedge clk);
            if (i == 86) checkOutput("timeout active before", 32'(bus.clock_active), 1);
            if (i == 87) begin
                checkOutput("timeout active after", 32'(bus.clock_active), 0);
                checkOutput("timeout period_error", 32'(bus.period_error), 1);
                checkOutput("timeout duty_error", 32'(bus.duty_error), 0);
                checkOutput("timeout err_count", 32'(bus.err_count), 1);
            end
            if (i == 112) checkOutput("restart active one rise", 32'(bus.clock_active), 0);
            if (i == 113) begin
                checkOutput("restart active two rises", 32'(bus.clock_active), 1);
                checkOutput("restart meas_period", 32'(bus.meas_period), 10);
            end
            if (i < 24) bus.clock_in = ((i % 10) < 4);
            else if (i >= 100) bus.clock_in = (((i - 100) % 10) < 4);
            else bus.clock_in = 1'b0;
        end

        // clear_err lands exactly on the third failing check
        prepare(16'd10, 16'd4, 16'd1);
        for (int i = 0; i <= 41; i++) begin
            @(negedge clk);
            bus.clear_err = 1'b0;
            if (i == 39) begin
                checkOutput("clear meas_valid", 32'(bus.meas_valid), 1);
                checkOutput("clear err_count before", 32'(bus.err_count), 2);
                bus.clear_err = 1'b1;
            end
            if (i == 40) begin
                checkOutput("clear period_error", 32'(bus.period_error), 1);
                checkOutput("clear duty_error", 32'(bus.duty_error), 0);
                checkOutput("clear err_count after", 32'(bus.err_count), 1);
            end
            bus.clock_in = ((i % 12) < 4);
        end

        // enable drops after the first rise; partial period is discarded
        prepare(16'd10, 16'd4, 16'd0);
        firstMv = -1;
        for (int i = 0; i <= 36; i++) begin
            @(negedge clk);
            if (bus.meas_valid && firstMv < 0) firstMv = i;
            if (i == 30) checkOutput("enable drop clock_active", 32'(bus.clock_active), 0);
            if (i == 5) bus.enable = 1'b0;
            if (i == 12) bus.enable = 1'b1;
            bus.clock_in = ((i % 10) < 4);
        end
        checkOutput("enable drop first meas_valid", 32'(firstMv), 33);

        // Reset mid-period clears everything; next measurement needs two fresh rises
        prepare(16'd9, 16'd4, 16'd0);
        firstMv = -1;
        for (int i = 0; i <= 50; i++) begin
            @(negedge clk);
            if (i > 25 && bus.meas_valid && firstMv < 0) begin
                firstMv = i;
                checkOutput("post-reset meas_period", 32'(bus.meas_period), 10);
            end
            if (i == 25) begin
                checkOutput("pre-reset period_error", 32'(bus.period_error), 1);
                checkOutput("pre-reset err_count", 32'(bus.err_count), 2);
                rst_n = 1'b0;
                #1;
                checkAllZero("mid reset");
            end
            if (i == 28) rst_n = 1'b1;
            bus.clock_in = ((i % 10) < 4);
        end
        checkOutput("post-reset first meas_valid", 32'(firstMv), 43);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_meas_checker.md
Name: clk_meas_checker

Overview:
- Receive-side counterpart of the clock VIP master.
- Oversamples an asynchronous `clock_in` with the fast sampling clock `clk`.
- Measures period and high time in `clk` cycles and compares them against expected values within a tolerance.
- Reports activity, configuration errors, sticky period/duty errors and an error count; sits on the slave/monitor end of the clock VIP interface.

Parameters:
- CNT_W, 16: width of all cycle counters and measurement fields.
- SYNC_STAGES, 2: synchronizer flops on `clock_in`; legal range 2..4.
- TIMEOUT_CYC, 1024: cycles without a rising edge before the clock is declared lost; must be < 2^CNT_W.

Ports:
- clk  in  1  sampling clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  measurement enable.
- clock_in  in  1  measured clock, asynchronous to `clk`.
- exp_period  in  CNT_W  expected period in `clk` cycles.
- exp_high  in  CNT_W  expected high time in `clk` cycles.
- tol  in  CNT_W  allowed absolute deviation (jitter budget) in cycles.
- clear_err  in  1  clears sticky errors and `err_count`.
- meas_period  out  CNT_W  last measured period.
- meas_high  out  CNT_W  last measured high time.
- meas_valid  out  1  one-cycle pulse when meas_* update.
- clock_active  out  1  valid periodic clock present.
- config_error  out  1  expected configuration illegal.
- period_error  out  1  sticky period-out-of-tolerance flag.
- duty_error  out  1  sticky high-time-out-of-tolerance flag.
- err_count  out  16  saturating count of erroneous measurements.

Behaviour:
- Reset (rst_n=0, async): every output 0; all counters, synchronizer and state cleared; state IDLE.
- Sync chain: `clock_in` passes through SYNC_STAGES flops to give `s`, plus one delay flop `s_d`.
  - rise = s & ~s_d; fall = ~s & s_d.
  - `clock_in` edge to rise/fall visible: SYNC_STAGES+1 cycles.
- config_error is combinational: 1 when exp_period==0 or exp_high>=exp_period or exp_high==0.
- States:
  - IDLE: entered when enable=0, from any state, effective next cycle. clock_active=0, meas_valid=0. meas_*, sticky flags and err_count hold. Go to WAIT_RISE when enable=1.
  - WAIT_RISE: on rise, load pcnt=1 and hcnt=1, go to MEASURE. No measurement is produced.
  - MEASURE:
    - Each cycle pcnt increments, saturating at all-ones. hcnt increments while s_d=1, saturating.
    - On fall, hcnt is latched into high_hold.
    - On rise: next cycle meas_period=pcnt, meas_high=high_hold, meas_valid=1 for one cycle, clock_active=1. pcnt and hcnt reload to 1 in the same cycle as the rise, so back-to-back periods are measured with no gap.
    - Example: rises detected at cycles 0 and 10, fall at cycle 4 give meas_period=10 and meas_high=4.
- Timeout: in MEASURE, when pcnt reaches TIMEOUT_CYC without a rise:
  - clock_active falls next cycle and state returns to WAIT_RISE.
  - Counts as one error: err_count+1; period_error=1 unless config_error=1.
  - Recovery requires two further rises.
- Checking (only in the meas_valid cycle, and only when config_error=0):
  - period_error sets if |meas_period-exp_period|>tol.
  - duty_error sets if |meas_high-exp_high|>tol.
  - Differences use unsigned magnitude with no wrap.
  - err_count increments by 1 if either check fails (not 2), saturating at 16'hFFFF.
- Sticky flags clear only on clear_err. If clear_err and a new failure occur in the same cycle, the flag ends up set and err_count ends up 1.
- Expected-value inputs are sampled at the check cycle; changing them mid-period is legal.
- enable drop mid-period: the partial period is discarded with no meas_valid. Re-enable starts from WAIT_RISE.
- Reset mid-operation: immediate clear as above; no measurement is produced from pre-reset edges.
- A `clock_in` pulse narrower than one `clk` period may be missed entirely. This is specified behaviour, not an error.

Test Plan:
- Reset/basic: enable=1; clock_in period 10 clk, high 4; exp 10/4, tol 0. First meas_valid at second rise +1 cycle, with meas_period=10 and meas_high=4. Then meas_valid every 10 cycles, clock_active=1, no errors, err_count=0.
- Period error: period 12, exp_period 10, tol 1. period_error=1, duty_error=0, err_count increments once per period. With tol=2, nothing sets.
- Duty error: period 10, high 6, exp_high 4. With tol 2, no error. With tol 1, duty_error=1. When both period and duty fail in one measurement, err_count increments by exactly 1.
- Timeout: TIMEOUT_CYC=64; hold clock_in low after a rise. clock_active=0 exactly 65 cycles after the rise is detected, period_error=1, err_count+1. On restart, clock_active returns only after two rises.
- Config: exp_high=exp_period=10 gives config_error=1. Drive out-of-tolerance clocks: no error flags set, err_count unchanged, measurements still update.
- Clear/reset: assert clear_err in the same cycle as a failing meas_valid; the flag remains 1. Assert rst_n=0 mid-period; all outputs 0 immediately, and the first measurement after release requires two rises.
